// File: rtl/key_search_coordinator.sv
// key_search_coordinator: launches a bank of brute-force key-search cores over
// contiguous sub-ranges of [KEY_MIN, KEY_MAX], resolves the first core to find a
// key (lowest index wins a tie), stops the bank and latches the result.
// Failure is reported when every core has exhausted its range or the cycle
// budget runs out. All status outputs, including LEDR, come straight from flops.
module key_search_coordinator #(
    parameter int                    NUM_CORES = 4,
    parameter int                    KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_MIN   = 24'h000000,
    parameter logic [KEY_WIDTH-1:0]  KEY_MAX   = 24'h3FFFFF,
    parameter int                    CNT_WIDTH = 32,
    parameter logic [CNT_WIDTH-1:0]  TIMEOUT   = 32'd0,
    localparam int                   WIN_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic                           core_stop,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_lo,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_hi,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES-1:0]           core_exhausted,
    input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           busy,
    output logic                           found,
    output logic                           failed,
    output logic                           timed_out,
    output logic [KEY_WIDTH-1:0]           key,
    output logic [WIN_W-1:0]               winner,
    output logic [CNT_WIDTH-1:0]           cycles,
    output logic [9:0]                     LEDR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SEARCH = 3'd2,
        S_FOUND  = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    // Range arithmetic is done one bit wider so a full-width span does not wrap.
    localparam logic [KEY_WIDTH:0] ONE_W   = (KEY_WIDTH+1)'(1);
    localparam logic [KEY_WIDTH:0] SPAN    = {1'b0, KEY_MAX} - {1'b0, KEY_MIN} + ONE_W;
    localparam logic [KEY_WIDTH:0] NCORE_W = (KEY_WIDTH+1)'(NUM_CORES);
    localparam logic [KEY_WIDTH:0] CHUNK   = SPAN / NCORE_W;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT - CNT_WIDTH'(1);

    // Static per-core ranges; the last core absorbs the division remainder.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_range
        localparam logic [KEY_WIDTH:0] IDX = (KEY_WIDTH+1)'(i);
        localparam logic [KEY_WIDTH:0] LO  = {1'b0, KEY_MIN} + IDX * CHUNK;
        localparam logic [KEY_WIDTH:0] HI  = (i == NUM_CORES-1) ? {1'b0, KEY_MAX}
                                                                 : (LO + CHUNK - ONE_W);
        assign core_lo[i*KEY_WIDTH +: KEY_WIDTH] = LO[KEY_WIDTH-1:0];
        assign core_hi[i*KEY_WIDTH +: KEY_WIDTH] = HI[KEY_WIDTH-1:0];
    end

    state_t                 state_r,  state_s;
    logic [NUM_CORES-1:0]   mask_r,   mask_s;
    logic [CNT_WIDTH-1:0]   cycles_r, cycles_s;
    logic [KEY_WIDTH-1:0]   key_r,    key_s;
    logic [WIN_W-1:0]       winner_r, winner_s;
    logic                   found_r,  found_s;
    logic                   failed_r, failed_s;
    logic                   timed_r,  timed_s;
    logic                   busy_r,   busy_s;
    logic                   stop_r,   stop_s;
    logic [NUM_CORES-1:0]   cstart_r, cstart_s;
    logic [9:0]             ledr_r,   ledr_s;

    logic [NUM_CORES-1:0]   mask_or_s;
    logic [WIN_W-1:0]       hit_idx_s;
    logic [KEY_WIDTH-1:0]   hit_key_s;
    logic [63:0]            win_wide_s;

    // Priority encoder: lowest-index found core and its reported key.
    always_comb begin
        hit_idx_s = '0;
        hit_key_s = '0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (core_found[i]) begin
                hit_idx_s = WIN_W'(i);
                hit_key_s = core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_s    = state_r;
        mask_s     = mask_r;
        cycles_s   = cycles_r;
        key_s      = key_r;
        winner_s   = winner_r;
        found_s    = found_r;
        failed_s   = failed_r;
        timed_s    = timed_r;
        stop_s     = stop_r;
        busy_s     = 1'b0;
        cstart_s   = '0;
        mask_or_s  = mask_r | core_exhausted;
        case (state_r)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (start) begin
                    state_s  = S_LAUNCH;
                    mask_s   = '0;
                    cycles_s = '0;
                    key_s    = '0;
                    winner_s = '0;
                    found_s  = 1'b0;
                    failed_s = 1'b0;
                    timed_s  = 1'b0;
                    stop_s   = 1'b0;
                    busy_s   = 1'b1;
                    cstart_s = '1;
                end else begin
                    state_s = state_r;
                end
            end
            S_LAUNCH: begin
                // Core status is not trusted until the cores have seen the launch.
                state_s = S_SEARCH;
                busy_s  = 1'b1;
            end
            S_SEARCH: begin
                busy_s   = 1'b1;
                mask_s   = mask_or_s;
                cycles_s = (cycles_r == {CNT_WIDTH{1'b1}}) ? cycles_r : (cycles_r + CNT_WIDTH'(1));
                if (|core_found) begin
                    state_s  = S_FOUND;
                    found_s  = 1'b1;
                    key_s    = hit_key_s;
                    winner_s = hit_idx_s;
                    stop_s   = 1'b1;
                    busy_s   = 1'b0;
                end else if (&mask_or_s) begin
                    state_s  = S_FAIL;
                    failed_s = 1'b1;
                    key_s    = '0;
                    winner_s = '0;
                    stop_s   = 1'b1;
                    busy_s   = 1'b0;
                end else if ((TIMEOUT != '0) && (cycles_r == TIMEOUT_LAST)) begin
                    state_s  = S_FAIL;
                    failed_s = 1'b1;
                    timed_s  = 1'b1;
                    key_s    = '0;
                    winner_s = '0;
                    stop_s   = 1'b1;
                    busy_s   = 1'b0;
                end else begin
                    state_s = S_SEARCH;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        win_wide_s = 64'(winner_s);
        ledr_s     = {win_wide_s[5:0], timed_s, busy_s, ~found_s, found_s};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r  <= S_IDLE;
            mask_r   <= '0;
            cycles_r <= '0;
            key_r    <= '0;
            winner_r <= '0;
            found_r  <= 1'b0;
            failed_r <= 1'b0;
            timed_r  <= 1'b0;
            busy_r   <= 1'b0;
            stop_r   <= 1'b0;
            cstart_r <= '0;
            ledr_r   <= 10'b00_0000_0010;
        end else begin
            state_r  <= state_s;
            mask_r   <= mask_s;
            cycles_r <= cycles_s;
            key_r    <= key_s;
            winner_r <= winner_s;
            found_r  <= found_s;
            failed_r <= failed_s;
            timed_r  <= timed_s;
            busy_r   <= busy_s;
            stop_r   <= stop_s;
            cstart_r <= cstart_s;
            ledr_r   <= ledr_s;
        end
    end

    assign core_start = cstart_r;
    assign core_stop  = stop_r;
    assign busy       = busy_r;
    assign found      = found_r;
    assign failed     = failed_r;
    assign timed_out  = timed_r;
    assign key        = key_r;
    assign winner     = winner_r;
    assign cycles     = cycles_r;
    assign LEDR       = ledr_r;

endmodule

// File: tb/tb_key_search_coordinator.sv
// Bench for key_search_coordinator: a 4-core instance (no timeout) and a 3-core
// instance (TIMEOUT=50). Search results are queued as expected records when the
// stimulus provokes them; per-instance monitors pop and compare on each new
// found/failed outcome.
module tb_key_search_coordinator;
    localparam int KW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            start_a;
    logic [3:0]      cs_a, cf_a, ce_a;
    logic            stop_a;
    logic [4*KW-1:0] lo_a, hi_a, ck_a;
    logic            busy_a, found_a, failed_a, to_a;
    logic [KW-1:0]   key_a;
    logic [1:0]      win_a;
    logic [31:0]     cyc_a;
    logic [9:0]      led_a;

    logic            start_b;
    logic [2:0]      cs_b, cf_b, ce_b;
    logic            stop_b;
    logic [3*KW-1:0] lo_b, hi_b, ck_b;
    logic            busy_b, found_b, failed_b, to_b;
    logic [KW-1:0]   key_b;
    logic [1:0]      win_b;
    logic [31:0]     cyc_b;
    logic [9:0]      led_b;

    key_search_coordinator dut_a (
        .CLOCK_50(clk), .reset(reset), .start(start_a),
        .core_start(cs_a), .core_stop(stop_a), .core_lo(lo_a), .core_hi(hi_a),
        .core_found(cf_a), .core_exhausted(ce_a), .core_key(ck_a),
        .busy(busy_a), .found(found_a), .failed(failed_a), .timed_out(to_a),
        .key(key_a), .winner(win_a), .cycles(cyc_a), .LEDR(led_a)
    );

    key_search_coordinator #(.NUM_CORES(3), .TIMEOUT(32'd50)) dut_b (
        .CLOCK_50(clk), .reset(reset), .start(start_b),
        .core_start(cs_b), .core_stop(stop_b), .core_lo(lo_b), .core_hi(hi_b),
        .core_found(cf_b), .core_exhausted(ce_b), .core_key(ck_b),
        .busy(busy_b), .found(found_b), .failed(failed_b), .timed_out(to_b),
        .key(key_b), .winner(win_b), .cycles(cyc_b), .LEDR(led_b)
    );

    typedef struct packed {
        logic        found;
        logic        failed;
        logic        timed_out;
        logic [23:0] key;
        logic [1:0]  winner;
        logic [31:0] cycles;
        logic [9:0]  ledr;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];
    res_t e_a, e_b;
    int   vectors = 0;
    int   miscompares = 0;
    logic done_prev_a = 1'b0;
    logic done_prev_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t e, input logic f, input logic fl,
                           input logic t, input logic [23:0] k, input logic [1:0] w,
                           input logic [31:0] c, input logic [9:0] l, input logic s);
        chk({tag, "_found"}, 64'(f), 64'(e.found));
        chk({tag, "_failed"}, 64'(fl), 64'(e.failed));
        chk({tag, "_timed_out"}, 64'(t), 64'(e.timed_out));
        chk({tag, "_key"}, 64'(k), 64'(e.key));
        chk({tag, "_winner"}, 64'(w), 64'(e.winner));
        chk({tag, "_cycles"}, 64'(c), 64'(e.cycles));
        chk({tag, "_ledr"}, 64'(l), 64'(e.ledr));
        chk({tag, "_core_stop"}, 64'(s), 64'd1);
    endtask

    // Monitor for the 4-core instance: compare each new outcome to the queue head.
    always @(negedge clk) begin
        if ((found_a | failed_a) && !done_prev_a) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result_a: found=%0d failed=%0d with nothing expected", found_a, failed_a);
            end else begin
                e_a = q_a.pop_front();
                cmp_res("res_a", e_a, found_a, failed_a, to_a, key_a, win_a, cyc_a, led_a, stop_a);
            end
        end
        done_prev_a <= found_a | failed_a;
    end

    // Monitor for the 3-core timeout instance.
    always @(negedge clk) begin
        if ((found_b | failed_b) && !done_prev_b) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result_b: found=%0d failed=%0d with nothing expected", found_b, failed_b);
            end else begin
                e_b = q_b.pop_front();
                cmp_res("res_b", e_b, found_b, failed_b, to_b, key_b, win_b, cyc_b, led_b, stop_b);
            end
        end
        done_prev_b <= found_b | failed_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (((q_a.size() + q_b.size()) != 0) && (n < 100)) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no result within 100 cycles, %0d still expected", name, q_a.size() + q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    // Start a search on instance A and step into SEARCH (cycles == 0).
    task automatic launch_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("core_start_a", 64'(cs_a), 64'hF);
        chk("busy_launch_a", 64'(busy_a), 64'd1);
        tick();
        chk("core_start_off_a", 64'(cs_a), 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; cf_a = '0; ce_a = '0; ck_a = '0;
        start_b = 1'b0; cf_b = '0; ce_b = '0; ck_b = '0;
        repeat (3) tick();

        // Reset state.
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_found", 64'(found_a), 64'd0);
        chk("rst_failed", 64'(failed_a), 64'd0);
        chk("rst_timed_out", 64'(to_a), 64'd0);
        chk("rst_key", 64'(key_a), 64'd0);
        chk("rst_winner", 64'(win_a), 64'd0);
        chk("rst_cycles", 64'(cyc_a), 64'd0);
        chk("rst_core_start", 64'(cs_a), 64'd0);
        chk("rst_core_stop", 64'(stop_a), 64'd0);
        chk("rst_ledr", 64'(led_a), 64'h002);
        reset = 1'b0;
        tick();

        // Static ranges, 4 cores.
        chk("lo_a0", 64'(lo_a[0*KW +: KW]), 64'h000000);
        chk("hi_a0", 64'(hi_a[0*KW +: KW]), 64'h0FFFFF);
        chk("lo_a1", 64'(lo_a[1*KW +: KW]), 64'h100000);
        chk("hi_a1", 64'(hi_a[1*KW +: KW]), 64'h1FFFFF);
        chk("lo_a2", 64'(lo_a[2*KW +: KW]), 64'h200000);
        chk("hi_a2", 64'(hi_a[2*KW +: KW]), 64'h2FFFFF);
        chk("lo_a3", 64'(lo_a[3*KW +: KW]), 64'h300000);
        chk("hi_a3", 64'(hi_a[3*KW +: KW]), 64'h3FFFFF);
        // Static ranges, 3 cores: chunk 0x155555, last core takes the remainder.
        chk("lo_b0", 64'(lo_b[0*KW +: KW]), 64'h000000);
        chk("hi_b0", 64'(hi_b[0*KW +: KW]), 64'h155554);
        chk("lo_b1", 64'(lo_b[1*KW +: KW]), 64'h155555);
        chk("hi_b1", 64'(hi_b[1*KW +: KW]), 64'h2AAAA9);
        chk("lo_b2", 64'(lo_b[2*KW +: KW]), 64'h2AAAAA);
        chk("hi_b2", 64'(hi_b[2*KW +: KW]), 64'h3FFFFF);

        // Core 2 finds after 100 SEARCH cycles.
        launch_a();
        repeat (100) tick();
        chk("no_early_found", 64'(found_a), 64'd0);
        cf_a = 4'b0100;
        ck_a = {24'h111111, 24'h2A1B3C, 24'h333333, 24'h444444};
        q_a.push_back('{1'b1, 1'b0, 1'b0, 24'h2A1B3C, 2'd2, 32'd101, {6'd2, 1'b0, 1'b0, 1'b0, 1'b1}});
        tick();
        cf_a = '0;
        drain("found_core2");

        // Relaunch from FOUND; tie between cores 1 and 3 goes to core 1.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("relaunch_found_clr", 64'(found_a), 64'd0);
        chk("relaunch_key_clr", 64'(key_a), 64'd0);
        chk("relaunch_stop_clr", 64'(stop_a), 64'd0);
        chk("relaunch_core_start", 64'(cs_a), 64'hF);
        tick();
        repeat (5) tick();
        cf_a = 4'b1010;
        ck_a = {24'h3ABCDE, 24'h0000EE, 24'h123456, 24'h0000DD};
        q_a.push_back('{1'b1, 1'b0, 1'b0, 24'h123456, 2'd1, 32'd6, {6'd1, 1'b0, 1'b0, 1'b0, 1'b1}});
        tick();
        cf_a = 4'b0001;
        ck_a = {24'h000000, 24'h000000, 24'h000000, 24'h0000AA};
        tick();
        cf_a = '0;
        chk("found_key_held", 64'(key_a), 64'h123456);
        drain("tie_core1");

        // Exhaustion pulses 0, 3, 1, 2: fail only after core 2.
        launch_a();
        ce_a = 4'b0001; tick(); ce_a = '0; tick();
        ce_a = 4'b1000; tick(); ce_a = '0; tick();
        ce_a = 4'b0010; tick(); ce_a = '0; tick();
        chk("no_early_fail", 64'(failed_a), 64'd0);
        q_a.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 32'd7, {6'd0, 1'b0, 1'b0, 1'b1, 1'b0}});
        ce_a = 4'b0100; tick(); ce_a = '0;
        drain("all_exhausted");

        // Core 2 exhausts in the same cycle an already-exhausted core 1 finds.
        launch_a();
        ce_a = 4'b0001; tick(); ce_a = '0; tick();
        ce_a = 4'b1000; tick(); ce_a = '0; tick();
        ce_a = 4'b0010; tick(); ce_a = '0; tick();
        ce_a = 4'b0100;
        cf_a = 4'b0010;
        ck_a = {24'h000000, 24'h000000, 24'h1F0F0F, 24'h000000};
        q_a.push_back('{1'b1, 1'b0, 1'b0, 24'h1F0F0F, 2'd1, 32'd7, {6'd1, 1'b0, 1'b0, 1'b0, 1'b1}});
        tick();
        ce_a = '0;
        cf_a = '0;
        drain("found_beats_exhaust");

        // Timeout on the 3-core instance after exactly 50 SEARCH cycles.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("core_start_b", 64'(cs_b), 64'h7);
        tick();
        q_b.push_back('{1'b0, 1'b1, 1'b1, 24'h000000, 2'd0, 32'd50, {6'd0, 1'b1, 1'b0, 1'b1, 1'b0}});
        repeat (49) tick();
        chk("timeout_not_yet", 64'(failed_b), 64'd0);
        tick();
        chk("timeout_now", 64'(failed_b), 64'd1);
        drain("timeout");

        // Reset in the middle of a search.
        launch_a();
        repeat (10) tick();
        chk("mid_busy_before_rst", 64'(busy_a), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_cycles", 64'(cyc_a), 64'd0);
        chk("mid_rst_core_stop", 64'(stop_a), 64'd0);
        chk("mid_rst_found_failed", 64'({found_a, failed_a, to_a}), 64'd0);
        chk("mid_rst_ledr", 64'(led_a), 64'h002);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_search_coordinator.md
Name: key_search_coordinator

Overview:
- Parametrised controller for a bank of NUM_CORES brute-force key-search cores (RC4 key-schedule/decrypt engines).
- Splits the key range [KEY_MIN, KEY_MAX] into contiguous per-core sub-ranges and launches all cores together.
- Resolves the first core to report a found key (lowest index wins a tie), broadcasts stop to all cores, and latches the winning key and core index.
- Reports failure when every core has exhausted its range or the cycle budget runs out; drives the board LEDs.

Parameters:
- NUM_CORES, 4, number of search cores, 1..64.
- KEY_WIDTH, 24, key width in bits.
- KEY_MIN, 0, first key searched.
- KEY_MAX, 24'h3FFFFF, last key searched, inclusive, KEY_MAX >= KEY_MIN + NUM_CORES - 1.
- CNT_WIDTH, 32, width of the elapsed-cycle counter.
- TIMEOUT, 0, cycle budget for SEARCH; 0 disables the timeout.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a search; level-sampled.
- core_start  out  NUM_CORES  one-cycle launch pulse to every core.
- core_stop  out  1  abort broadcast to all cores.
- core_lo  out  NUM_CORES*KEY_WIDTH  per-core range start; core i occupies slice i.
- core_hi  out  NUM_CORES*KEY_WIDTH  per-core range end, inclusive.
- core_found  in  NUM_CORES  core i has found a valid key; level.
- core_exhausted  in  NUM_CORES  core i finished its range without a hit; level or pulse.
- core_key  in  NUM_CORES*KEY_WIDTH  key reported by core i; valid while core_found[i]=1.
- busy  out  1  search in progress (LAUNCH or SEARCH).
- found  out  1  search succeeded.
- failed  out  1  search ended without a hit.
- timed_out  out  1  the failure was caused by TIMEOUT.
- key  out  KEY_WIDTH  winning key.
- winner  out  max(1,$clog2(NUM_CORES))  index of the winning core.
- cycles  out  CNT_WIDTH  SEARCH cycles elapsed in the current or last search.
- LEDR  out  10  board LEDs.

Behaviour:
- Ranges are elaboration-time constants:
  - span = KEY_MAX-KEY_MIN+1; chunk = span/NUM_CORES (integer division).
  - core_lo[i] = KEY_MIN + i*chunk.
  - core_hi[i] = core_lo[i]+chunk-1, except the last core, whose core_hi = KEY_MAX (it absorbs the remainder).
- Reset: state IDLE. Reset values: busy=0, found=0, failed=0, timed_out=0, key=0, winner=0, cycles=0, core_start=0, core_stop=0, exhausted mask=0. Reset always wins over every other input, including in mid-search. Cores share the same reset.
- FSM states are IDLE, LAUNCH, SEARCH, FOUND, FAIL. All outputs are registered.
- IDLE, FOUND, FAIL with start=1:
  - Next state is LAUNCH.
  - Clear found, failed, timed_out, key, winner, cycles and the exhausted mask; deassert core_stop.
  - A held start re-launches only from IDLE/FOUND/FAIL and is ignored while busy.
- LAUNCH:
  - core_start = all ones for exactly this one cycle; busy=1.
  - Always proceeds to SEARCH. core_found and core_exhausted are ignored in this state.
- SEARCH (busy=1):
  - cycles increments every cycle and saturates at all ones.
  - The mask ORs in core_exhausted each cycle, making it sticky.
  - Priority each cycle, highest first:
    1. Any core_found: winner = lowest set index, key = that core's core_key slice, go to FOUND.
    2. Mask (including this cycle's bits) is all ones: go to FAIL.
    3. TIMEOUT != 0 and cycles == TIMEOUT-1: go to FAIL with timed_out=1.
  - A found in the same cycle as the last exhaustion or the timeout is reported as FOUND.
  - A found from a core whose exhausted bit is set still counts.
- FOUND:
  - found=1, busy=0, core_stop=1 (asserted the cycle after detection and held).
  - key and winner are held; later core_found activity is ignored.
- FAIL:
  - failed=1, busy=0, core_stop=1 held; key=0, winner=0.
- Latency:
  - start to core_start is 1 cycle.
  - core_found to found/core_stop is 1 cycle.
  - cycles in FOUND equals the number of SEARCH cycles.
- LEDR mapping:
  - LEDR[0] = found.
  - LEDR[1] = ~found (so it is also lit in IDLE, FAIL and during a search).
  - LEDR[2] = busy.
  - LEDR[3] = timed_out.
  - LEDR[9:4] = winner, zero-extended and truncated to 6 bits.

Test Plan:
- NUM_CORES=4 defaults: reset, then start pulse -> core_start=4'b1111 for one cycle. Core ranges:
  - core 0: lo 0x000000, hi 0x0FFFFF
  - core 1: lo 0x100000, hi 0x1FFFFF
  - core 2: lo 0x200000, hi 0x2FFFFF
  - core 3: lo 0x300000, hi 0x3FFFFF
- SEARCH 100 cycles, then core_found=4'b0100 with core 2 key=0x2A1B3C -> next cycle found=1, key=0x2A1B3C, winner=2, core_stop=1, cycles=101, LEDR[1:0]=2'b01.
- Same cycle core_found=4'b1010 -> winner=1 and core 1's key is latched.
- Exhaustion pulses from cores 0, 3, 1, 2 on separate cycles -> failed=1 only after core 2's pulse. Variant: core 2 exhausts in the same cycle core 1 finds -> found=1.
- TIMEOUT=50 with no core activity -> failed=1, timed_out=1 after exactly 50 SEARCH cycles.
- NUM_CORES=3 -> chunk 0x155555 and core 2 covers 0x2AAAAA..0x3FFFFF.
- Reset asserted mid-SEARCH -> all outputs zero the next cycle.
- A new start from FOUND -> result is cleared and a relaunch occurs.
